// File: rtl/alu_imm_pipeline.sv
// RV32I OP-IMM execution pipe: operand collect (OC) stage, combinational EX, registered WB output.
// Optional performance counters are built when ALU_IMM_PIPELINE_PERF_EN is defined.
module alu_imm_pipeline #(
  parameter int FAST_FORWARD_PIPE_COUNT     = 4,
  parameter int LOG_FAST_FORWARD_PIPE_COUNT = $clog2(FAST_FORWARD_PIPE_COUNT),
  parameter int PRF_BANK_COUNT              = 4,
  parameter int LOG_PRF_BANK_COUNT          = $clog2(PRF_BANK_COUNT),
  parameter int LOG_PR_COUNT                = 7,
  parameter int LOG_ROB_ENTRIES             = 7
) (
  input  logic                                   CLK,
  input  logic                                   RST,

  input  logic                                   issue_valid,
  input  logic [3:0]                             issue_op,
  input  logic [11:0]                            issue_imm12,
  input  logic                                   issue_A_is_reg,
  input  logic                                   issue_A_is_bus_forward,
  input  logic                                   issue_A_is_fast_forward,
  input  logic [LOG_FAST_FORWARD_PIPE_COUNT-1:0] issue_A_fast_forward_pipe,
  input  logic [LOG_PRF_BANK_COUNT-1:0]          issue_A_bank,
  input  logic [LOG_PR_COUNT-1:0]                issue_dest_PR,
  input  logic [LOG_ROB_ENTRIES-1:0]             issue_ROB_index,
  output logic                                   issue_ready,

  input  logic [PRF_BANK_COUNT-1:0]              reg_read_ack_by_bank,
  input  logic [PRF_BANK_COUNT*32-1:0]           reg_read_data_by_bank,
  input  logic [PRF_BANK_COUNT*32-1:0]           WB_bus_data_by_bank,
  input  logic [FAST_FORWARD_PIPE_COUNT*32-1:0]  fast_forward_data_by_pipe,

  output logic                                   WB_valid,
  output logic [31:0]                            WB_data,
  output logic [LOG_PR_COUNT-1:0]                WB_PR,
  output logic [LOG_ROB_ENTRIES-1:0]             WB_ROB_index,
  input  logic                                   WB_ready
`ifdef ALU_IMM_PIPELINE_PERF_EN
  ,
  output logic [31:0]                            perf_issue_count,
  output logic [31:0]                            perf_stall_count
`endif
);

  logic                                   oc_valid;
  logic                                   oc_first;
  logic [3:0]                             oc_op;
  logic [11:0]                            oc_imm12;
  logic                                   oc_is_reg;
  logic                                   oc_is_bus;
  logic                                   oc_is_ff;
  logic [LOG_FAST_FORWARD_PIPE_COUNT-1:0] oc_pipe;
  logic [LOG_PRF_BANK_COUNT-1:0]          oc_bank;
  logic [LOG_PR_COUNT-1:0]                oc_dest_PR;
  logic [LOG_ROB_ENTRIES-1:0]             oc_ROB_index;
  logic                                   oc_captured;
  logic [31:0]                            oc_A;

  logic        bus_now;
  logic        ff_now;
  logic        reg_now;
  logic        src_none;
  logic        capture_now;
  logic        operand_avail;
  logic [31:0] capture_data;
  logic [31:0] operand_A;
  logic        oc_advance;
  logic        issue_fire;

  logic [31:0] imm_sext;
  logic [4:0]  shamt;
  logic [31:0] ex_result;

  // Forwarded values exist only in the first OC cycle; the PRF path waits for an ack.
  // Source priority is bus > fast > reg when the IQ flags are not one-hot.
  always_comb begin
    bus_now  = oc_first & oc_is_bus;
    ff_now   = oc_first & ~oc_is_bus & oc_is_ff;
    reg_now  = ~oc_is_bus & ~oc_is_ff & oc_is_reg & reg_read_ack_by_bank[oc_bank];
    src_none = ~oc_is_bus & ~oc_is_ff & ~oc_is_reg;

    capture_now = ~oc_captured & (bus_now | ff_now | reg_now);

    capture_data = 32'h0;
    if (bus_now)
      capture_data = WB_bus_data_by_bank[oc_bank*32 +: 32];
    else if (ff_now)
      capture_data = fast_forward_data_by_pipe[oc_pipe*32 +: 32];
    else if (reg_now)
      capture_data = reg_read_data_by_bank[oc_bank*32 +: 32];

    operand_A     = oc_captured ? oc_A : capture_data;
    operand_avail = oc_captured | capture_now | src_none;

    oc_advance  = oc_valid & operand_avail & (~WB_valid | WB_ready);
    issue_ready = ~oc_valid | oc_advance;
    issue_fire  = issue_valid & issue_ready;
  end

  always_comb begin
    imm_sext  = {{20{oc_imm12[11]}}, oc_imm12};
    shamt     = oc_imm12[4:0];
    ex_result = 32'h0;
    case (oc_op[2:0])
      3'b000: ex_result = operand_A + imm_sext;
      3'b001: ex_result = operand_A << shamt;
      3'b010: ex_result = {31'h0, $signed(operand_A) < $signed(imm_sext)};
      3'b011: ex_result = {31'h0, operand_A < imm_sext};
      3'b100: ex_result = operand_A ^ imm_sext;
      3'b101: begin
        if (oc_op[3])
          ex_result = $unsigned($signed(operand_A) >>> shamt);
        else
          ex_result = operand_A >> shamt;
      end
      3'b110: ex_result = operand_A | imm_sext;
      3'b111: ex_result = operand_A & imm_sext;
      default: ex_result = 32'h0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      oc_valid     <= 1'b0;
      oc_first     <= 1'b0;
      oc_op        <= '0;
      oc_imm12     <= '0;
      oc_is_reg    <= 1'b0;
      oc_is_bus    <= 1'b0;
      oc_is_ff     <= 1'b0;
      oc_pipe      <= '0;
      oc_bank      <= '0;
      oc_dest_PR   <= '0;
      oc_ROB_index <= '0;
      oc_captured  <= 1'b0;
      oc_A         <= '0;
    end else if (issue_fire) begin
      oc_valid     <= 1'b1;
      oc_first     <= 1'b1;
      oc_op        <= issue_op;
      oc_imm12     <= issue_imm12;
      oc_is_reg    <= issue_A_is_reg;
      oc_is_bus    <= issue_A_is_bus_forward;
      oc_is_ff     <= issue_A_is_fast_forward;
      oc_pipe      <= issue_A_fast_forward_pipe;
      oc_bank      <= issue_A_bank;
      oc_dest_PR   <= issue_dest_PR;
      oc_ROB_index <= issue_ROB_index;
      oc_captured  <= 1'b0;
    end else if (oc_advance) begin
      oc_valid    <= 1'b0;
      oc_first    <= 1'b0;
      oc_captured <= 1'b0;
    end else if (oc_valid) begin
      oc_first <= 1'b0;
      if (capture_now) begin
        oc_captured <= 1'b1;
        oc_A        <= capture_data;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      WB_valid     <= 1'b0;
      WB_data      <= '0;
      WB_PR        <= '0;
      WB_ROB_index <= '0;
    end else if (oc_advance) begin
      WB_valid     <= 1'b1;
      WB_data      <= ex_result;
      WB_PR        <= oc_dest_PR;
      WB_ROB_index <= oc_ROB_index;
    end else if (WB_ready) begin
      WB_valid <= 1'b0;
    end
  end

`ifdef ALU_IMM_PIPELINE_PERF_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_issue_count <= '0;
      perf_stall_count <= '0;
    end else begin
      if (issue_fire)
        perf_issue_count <= perf_issue_count + 32'd1;
      if (oc_valid & ~oc_advance)
        perf_stall_count <= perf_stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_imm_pipeline.sv
// Self-checking bench for alu_imm_pipeline: directed latency/backpressure/reset scenarios
// plus a randomized run scored against an in-order reference queue.
module tb_alu_imm_pipeline;

  localparam int NPIPE = 4;
  localparam int NBANK = 4;
  localparam int LPR   = 7;
  localparam int LROB  = 7;

  logic              CLK = 1'b0;
  logic              RST;
  logic              issue_valid;
  logic [3:0]        issue_op;
  logic [11:0]       issue_imm12;
  logic              issue_A_is_reg;
  logic              issue_A_is_bus_forward;
  logic              issue_A_is_fast_forward;
  logic [1:0]        issue_A_fast_forward_pipe;
  logic [1:0]        issue_A_bank;
  logic [LPR-1:0]    issue_dest_PR;
  logic [LROB-1:0]   issue_ROB_index;
  logic              issue_ready;
  logic [NBANK-1:0]  reg_read_ack_by_bank;
  logic [NBANK*32-1:0] reg_read_data_by_bank;
  logic [NBANK*32-1:0] WB_bus_data_by_bank;
  logic [NPIPE*32-1:0] fast_forward_data_by_pipe;
  logic              WB_valid;
  logic [31:0]       WB_data;
  logic [LPR-1:0]    WB_PR;
  logic [LROB-1:0]   WB_ROB_index;
  logic              WB_ready;

  int npass = 0;
  int ntotal = 0;

  always #5 CLK = ~CLK;

  alu_imm_pipeline dut (
    .CLK                       (CLK),
    .RST                       (RST),
    .issue_valid               (issue_valid),
    .issue_op                  (issue_op),
    .issue_imm12               (issue_imm12),
    .issue_A_is_reg            (issue_A_is_reg),
    .issue_A_is_bus_forward    (issue_A_is_bus_forward),
    .issue_A_is_fast_forward   (issue_A_is_fast_forward),
    .issue_A_fast_forward_pipe (issue_A_fast_forward_pipe),
    .issue_A_bank              (issue_A_bank),
    .issue_dest_PR             (issue_dest_PR),
    .issue_ROB_index           (issue_ROB_index),
    .issue_ready               (issue_ready),
    .reg_read_ack_by_bank      (reg_read_ack_by_bank),
    .reg_read_data_by_bank     (reg_read_data_by_bank),
    .WB_bus_data_by_bank       (WB_bus_data_by_bank),
    .fast_forward_data_by_pipe (fast_forward_data_by_pipe),
    .WB_valid                  (WB_valid),
    .WB_data                   (WB_data),
    .WB_PR                     (WB_PR),
    .WB_ROB_index              (WB_ROB_index),
    .WB_ready                  (WB_ready)
  );

  // Reference: RV32I OP-IMM semantics from the instruction definitions.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [11:0] imm12,
                                          input logic [31:0] a);
    int          imm_i;
    int          a_i;
    int unsigned sh;
    logic [31:0] imm_u;
    imm_i = int'($signed(imm12));
    imm_u = imm_i;
    a_i   = a;
    sh    = imm12[4:0];
    case (op[2:0])
      3'd0: return a + imm_u;
      3'd1: return a * (32'd1 << sh);
      3'd2: return (a_i < imm_i) ? 32'd1 : 32'd0;
      3'd3: return (a < imm_u) ? 32'd1 : 32'd0;
      3'd4: return a ^ imm_u;
      3'd5: begin
        if (op[3]) return $unsigned(a_i >>> sh);
        return a / (32'd1 << sh);
      end
      3'd6: return a | imm_u;
      default: return a & imm_u;
    endcase
  endfunction

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_op = 0; issue_imm12 = 0;
    issue_A_is_reg = 0; issue_A_is_bus_forward = 0; issue_A_is_fast_forward = 0;
    issue_A_fast_forward_pipe = 0; issue_A_bank = 0; issue_dest_PR = 0; issue_ROB_index = 0;
    reg_read_ack_by_bank = 0; WB_ready = 1;
  endtask

  task automatic set_issue(input logic [3:0] op, input logic [11:0] imm, input logic is_reg,
                           input logic is_bus, input logic is_ff, input logic [1:0] pipe,
                           input logic [1:0] bank, input logic [LPR-1:0] pr,
                           input logic [LROB-1:0] rob);
    issue_valid = 1; issue_op = op; issue_imm12 = imm;
    issue_A_is_reg = is_reg; issue_A_is_bus_forward = is_bus; issue_A_is_fast_forward = is_ff;
    issue_A_fast_forward_pipe = pipe; issue_A_bank = bank;
    issue_dest_PR = pr; issue_ROB_index = rob;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1;
    cyc(); cyc();
    RST = 0;
    #1;
    ntotal++; if (WB_valid !== 1'b0) $display("FAIL reset_wb_valid: got %b want 0", WB_valid); else npass++;
    ntotal++; if (WB_data !== 32'h0) $display("FAIL reset_wb_data: got %h want 0", WB_data); else npass++;
    ntotal++; if (WB_PR !== '0) $display("FAIL reset_wb_pr: got %h want 0", WB_PR); else npass++;
    ntotal++; if (WB_ROB_index !== '0) $display("FAIL reset_wb_rob: got %h want 0", WB_ROB_index); else npass++;
    ntotal++; if (issue_ready !== 1'b1) $display("FAIL reset_issue_ready: got %b want 1", issue_ready); else npass++;
    cyc();
  endtask

  task automatic test_addi_x0();
    set_issue(4'b0000, 12'hFFF, 0, 0, 0, 2'd0, 2'd0, 7'h15, 7'h2A);
    #1;
    ntotal++; if (issue_ready !== 1'b1) $display("FAIL addi_issue_ready: got %b want 1", issue_ready); else npass++;
    cyc();
    issue_valid = 0;
    #1;
    ntotal++; if (WB_valid !== 1'b0) $display("FAIL addi_early_valid: got %b want 0", WB_valid); else npass++;
    cyc();
    #1;
    ntotal++; if (WB_valid !== 1'b1) $display("FAIL addi_valid: got %b want 1", WB_valid); else npass++;
    ntotal++; if (WB_data !== 32'hFFFF_FFFF) $display("FAIL addi_data: got %h want ffffffff", WB_data); else npass++;
    ntotal++; if (WB_PR !== 7'h15) $display("FAIL addi_pr: got %h want 15", WB_PR); else npass++;
    ntotal++; if (WB_ROB_index !== 7'h2A) $display("FAIL addi_rob: got %h want 2a", WB_ROB_index); else npass++;
    cyc();
    #1;
    ntotal++; if (WB_valid !== 1'b0) $display("FAIL addi_drop: got %b want 0", WB_valid); else npass++;
  endtask

  task automatic test_srai_bus();
    WB_bus_data_by_bank = {$urandom, $urandom, $urandom, $urandom};
    set_issue(4'b1101, 12'h404, 0, 1, 0, 2'd0, 2'd1, 7'h03, 7'h04);
    cyc();
    idle_inputs();
    WB_bus_data_by_bank = {$urandom, $urandom, 32'h8000_0000, $urandom};
    cyc();
    WB_bus_data_by_bank = {$urandom, $urandom, $urandom, $urandom};
    #1;
    ntotal++; if (WB_valid !== 1'b1) $display("FAIL srai_valid: got %b want 1", WB_valid); else npass++;
    ntotal++; if (WB_data !== 32'hF800_0000) $display("FAIL srai_data: got %h want f8000000", WB_data); else npass++;
    cyc();
  endtask

  task automatic test_reg_late();
    reg_read_data_by_bank = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    set_issue(4'b0011, 12'h008, 1, 0, 0, 2'd0, 2'd2, 7'h11, 7'h22);
    cyc();
    idle_inputs();
    reg_read_ack_by_bank = 4'b0001;
    #1;
    ntotal++; if (issue_ready !== 1'b0) $display("FAIL reg_late_ready_n1: got %b want 0", issue_ready); else npass++;
    cyc();
    reg_read_ack_by_bank = 4'b0000;
    #1;
    ntotal++; if (issue_ready !== 1'b0) $display("FAIL reg_late_ready_n2: got %b want 0", issue_ready); else npass++;
    cyc();
    reg_read_ack_by_bank = 4'b0100;
    reg_read_data_by_bank = {32'hFFFF_FFFF, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    #1;
    ntotal++; if (WB_valid !== 1'b0) $display("FAIL reg_late_early_valid: got %b want 0", WB_valid); else npass++;
    ntotal++; if (issue_ready !== 1'b1) $display("FAIL reg_late_ready_n3: got %b want 1", issue_ready); else npass++;
    cyc();
    reg_read_ack_by_bank = 4'b0000;
    reg_read_data_by_bank = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    #1;
    ntotal++; if (WB_valid !== 1'b1) $display("FAIL reg_late_valid: got %b want 1", WB_valid); else npass++;
    ntotal++; if (WB_data !== 32'h1) $display("FAIL reg_late_data: got %h want 1", WB_data); else npass++;
    cyc();
  endtask

  task automatic test_backpressure();
    set_issue(4'b0000, 12'h123, 0, 0, 0, 2'd0, 2'd0, 7'h01, 7'h01);
    #1;
    ntotal++; if (issue_ready !== 1'b1) $display("FAIL bp_ready_a: got %b want 1", issue_ready); else npass++;
    cyc();
    set_issue(4'b0100, 12'h0FF, 0, 1, 0, 2'd0, 2'd0, 7'h02, 7'h02);
    #1;
    ntotal++; if (issue_ready !== 1'b1) $display("FAIL bp_ready_b: got %b want 1", issue_ready); else npass++;
    cyc();
    set_issue(4'b0110, 12'h800, 0, 0, 0, 2'd0, 2'd0, 7'h03, 7'h03);
    WB_bus_data_by_bank = {$urandom, $urandom, $urandom, 32'h1234_5600};
    WB_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      ntotal++; if (WB_valid !== 1'b1 || WB_data !== 32'h123) $display("FAIL bp_hold_wb: cycle %0d got %b/%h want 1/00000123", i, WB_valid, WB_data); else npass++;
      ntotal++; if (issue_ready !== 1'b0) $display("FAIL bp_hold_ready: cycle %0d got %b want 0", i, issue_ready); else npass++;
      cyc();
      WB_bus_data_by_bank = {$urandom, $urandom, $urandom, 32'hDEAD_0000};
    end
    WB_ready = 1;
    #1;
    ntotal++; if (issue_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", issue_ready); else npass++;
    cyc();
    issue_valid = 0;
    #1;
    ntotal++; if (WB_valid !== 1'b1 || WB_data !== 32'h1234_56FF || WB_PR !== 7'h02) $display("FAIL bp_second: got %b/%h/%h want 1/123456ff/02", WB_valid, WB_data, WB_PR); else npass++;
    cyc();
    #1;
    ntotal++; if (WB_valid !== 1'b1 || WB_data !== 32'hFFFF_F800 || WB_PR !== 7'h03) $display("FAIL bp_third: got %b/%h/%h want 1/fffff800/03", WB_valid, WB_data, WB_PR); else npass++;
    cyc();
    #1;
    ntotal++; if (WB_valid !== 1'b0) $display("FAIL bp_drain: got %b want 0", WB_valid); else npass++;
  endtask

  task automatic test_ff_reset();
    fast_forward_data_by_pipe = {$urandom, $urandom, $urandom, $urandom};
    set_issue(4'b0111, 12'h0F0, 0, 0, 1, 2'd3, 2'd0, 7'h05, 7'h06);
    cyc();
    idle_inputs();
    fast_forward_data_by_pipe = {32'h0000_0010, $urandom, $urandom, $urandom};
    RST = 1;
    cyc();
    RST = 0;
    #1;
    ntotal++; if (WB_valid !== 1'b0) $display("FAIL ffrst_valid: got %b want 0", WB_valid); else npass++;
    ntotal++; if (issue_ready !== 1'b1) $display("FAIL ffrst_ready: got %b want 1", issue_ready); else npass++;
    ntotal++; if (WB_data !== 32'h0) $display("FAIL ffrst_data: got %h want 0", WB_data); else npass++;
    cyc();
    #1;
    ntotal++; if (WB_valid !== 1'b0) $display("FAIL ffrst_late_valid: got %b want 0", WB_valid); else npass++;
  endtask

  typedef struct { logic [31:0] data; logic [LPR-1:0] pr; logic [LROB-1:0] rob; } exp_t;

  task automatic test_random();
    exp_t        q[$];
    exp_t        e;
    logic [31:0] a;
    int          issued = 0;
    int          received = 0;
    int          cycles = 0;
    bit          holding = 0;
    localparam int NOPS = 150;
    idle_inputs();
    reg_read_data_by_bank     = {$urandom, $urandom, $urandom, $urandom};
    WB_bus_data_by_bank       = {$urandom, $urandom, $urandom, $urandom};
    fast_forward_data_by_pipe = {$urandom, $urandom, $urandom, $urandom};
    while ((issued < NOPS || q.size() != 0) && cycles < 3000) begin
      if (!holding && issued < NOPS && $urandom_range(0, 4) != 0) begin
        logic [2:0] fl;
        fl = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 3) != 0) fl = 3'(1 << $urandom_range(0, 3)) & 3'b111;
        set_issue(4'($urandom), 12'($urandom), fl[0], fl[1], fl[2], 2'($urandom), 2'($urandom),
                  7'($urandom), 7'(issued));
        holding = 1;
      end
      issue_valid = holding;
      reg_read_ack_by_bank = 4'($urandom);
      WB_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (WB_valid && WB_ready) begin
        ntotal++;
        if (q.size() == 0) begin
          $display("FAIL rand_unexpected: got rob %h want no result", WB_ROB_index);
        end else begin
          e = q.pop_front();
          if (WB_data !== e.data || WB_PR !== e.pr || WB_ROB_index !== e.rob)
            $display("FAIL rand_result: got %h/%h/%h want %h/%h/%h", WB_data, WB_PR, WB_ROB_index, e.data, e.pr, e.rob);
          else npass++;
        end
        received++;
      end
      if (issue_valid && issue_ready) begin
        if (issue_A_is_bus_forward)       a = WB_bus_data_by_bank[issue_A_bank*32 +: 32];
        else if (issue_A_is_fast_forward) a = fast_forward_data_by_pipe[issue_A_fast_forward_pipe*32 +: 32];
        else if (issue_A_is_reg)          a = reg_read_data_by_bank[issue_A_bank*32 +: 32];
        else                              a = 32'h0;
        e.data = ref_alu(issue_op, issue_imm12, a);
        e.pr   = issue_dest_PR;
        e.rob  = issue_ROB_index;
        q.push_back(e);
        issued++;
        holding = 0;
      end
      cyc();
      issue_valid = holding;
      cycles++;
    end
    ntotal++;
    if (received !== NOPS) $display("FAIL rand_count: got %0d results want %0d (cycles %0d)", received, NOPS, cycles);
    else npass++;
    idle_inputs();
    cyc();
  endtask

  initial begin
    RST = 1;
    idle_inputs();
    reg_read_data_by_bank = '0;
    WB_bus_data_by_bank = '0;
    fast_forward_data_by_pipe = '0;
    test_reset();
    test_addi_x0();
    test_srai_bus();
    test_reg_late();
    test_backpressure();
    test_ff_reset();
    test_random();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
